// File: rtl/time_adjust_ctrl.sv
// Front-panel sequencer for the time_float counter chain: debounced keys with
// add auto-repeat, RUN/EDIT mode machine, ms-digit zeroing on entry to EDIT,
// shaped add/clr pulses, idle timeout and a display blink strobe.

// One key lane: 2-FF synchroniser, debouncer, press strobe and optional auto-repeat.
module time_adjust_ctrl_key #(
    parameter int DEB_CYC   = 1_000_000,
    parameter bit REP_EN    = 1'b0,
    parameter int REP_DELAY = 25_000_000,
    parameter int REP_RATE  = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic rep_en,
    output logic evt
);
    localparam int CW      = $clog2(DEB_CYC + 1);
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          db_q, db_d, press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_on_q, rep_on_d;
    logic          rep_active, rep_hit;

    // Debounce: a new level is accepted after DEB_CYC consecutive differing samples.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CW'(DEB_CYC - 1)) db_d = sync2_q;
            else                           cnt_d = cnt_q + CW'(1);
        end
        press_d = db_q & ~db_d;
    end

    // Auto-repeat: first hit REP_DELAY cycles after the press, then every REP_RATE.
    always_comb begin
        rep_active = REP_EN && rep_en && !db_q && !press_q;
        rep_hit    = rep_active && (rep_on_q ? (rep_q == RW'(REP_RATE - 1))
                                             : (rep_q == RW'(REP_DELAY - 1)));
        rep_d      = '0;
        rep_on_d   = 1'b0;
        if (rep_active) begin
            if (rep_hit) begin
                rep_on_d = 1'b1;
            end else begin
                rep_d    = rep_q + RW'(1);
                rep_on_d = rep_on_q;
            end
        end
        evt = press_q | rep_hit;
    end

    // Lane state; keys read as released out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            db_q     <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rep_q    <= '0;
            rep_on_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rep_q    <= rep_d;
            rep_on_q <= rep_on_d;
        end
    end
endmodule

module time_adjust_ctrl #(
    parameter int DEB_CYC     = 1_000_000,
    parameter int PULSE_CYC   = 4,
    parameter int REP_DELAY   = 25_000_000,
    parameter int REP_RATE    = 5_000_000,
    parameter int TIMEOUT_CYC = 500_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_next,
    input  logic       key_add,
    input  logic       key_clr,
    output logic       adjust,
    output logic [3:0] select,
    output logic       add,
    output logic       clr,
    output logic       blink
);
    localparam int NUM_KEYS = 4;
    localparam int K_MODE = 0, K_NEXT = 1, K_ADD = 2, K_CLR = 3;
    localparam int PW = $clog2(2 * PULSE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [2:0] {S_RUN, S_ZMS0, S_ZMS1, S_EDIT, S_PULSE, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            sel_q, sel_d;
    logic [PW-1:0]         ph_q, ph_d;
    logic                  op_clr_q, op_clr_d;
    logic                  mode_pend_q, mode_pend_d;
    logic [TW-1:0]         to_q, to_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  blink_q, blink_d;
    logic [NUM_KEYS-1:0]   keys_n, evt;
    logic                  rep_en;
    logic                  ev_mode, ev_clr, ev_add, ev_next;

    assign keys_n = {key_clr, key_add, key_next, key_mode};
    assign rep_en = (state_q != S_RUN);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        time_adjust_ctrl_key #(
            .DEB_CYC  (DEB_CYC),
            .REP_EN   (g == K_ADD),
            .REP_DELAY(REP_DELAY),
            .REP_RATE (REP_RATE)
        ) u_key (
            .clk   (CLOCK_50),
            .rst_n (rst_n),
            .key_n (keys_n[g]),
            .rep_en(rep_en),
            .evt   (evt[g])
        );
    end

    // Same-cycle priority mode > clr > add > next; losers are dropped.
    always_comb begin
        ev_mode = evt[K_MODE];
        ev_clr  = evt[K_CLR] & ~evt[K_MODE];
        ev_add  = evt[K_ADD] & ~evt[K_MODE] & ~evt[K_CLR];
        ev_next = evt[K_NEXT] & ~evt[K_MODE] & ~evt[K_CLR] & ~evt[K_ADD];
    end

    // Next-state: mode machine, field select, phase and idle-timeout counters.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ph_d        = '0;
        op_clr_d    = op_clr_q;
        mode_pend_d = mode_pend_q;
        to_d        = '0;
        case (state_q)
            S_RUN: begin
                sel_d       = 4'd0;
                mode_pend_d = 1'b0;
                if (ev_mode) state_d = S_ZMS0;
            end
            S_ZMS0, S_ZMS1: begin
                if (ev_mode) mode_pend_d = 1'b1;
                // clr high for the first PULSE_CYC, low for the next PULSE_CYC
                if (ph_q == PW'(2 * PULSE_CYC - 1)) begin
                    if (state_q == S_ZMS0) begin
                        state_d = S_ZMS1;
                        sel_d   = 4'd1;
                    end else begin
                        state_d = S_EDIT;
                        sel_d   = 4'd2;
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_EDIT: begin
                if (ev_mode || mode_pend_q) begin
                    state_d     = S_RUN;
                    sel_d       = 4'd0;
                    mode_pend_d = 1'b0;
                end else if (ev_clr || ev_add) begin
                    state_d  = S_PULSE;
                    op_clr_d = ev_clr;
                end else if (ev_next) begin
                    sel_d = (sel_q == 4'd15) ? 4'd2 : sel_q + 4'd1;
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = S_RUN;
                    sel_d   = 4'd0;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_PULSE, S_GAP: begin
                if (ev_mode) mode_pend_d = 1'b1;
                if (ph_q == PW'(PULSE_CYC - 1)) state_d = (state_q == S_PULSE) ? S_GAP : S_EDIT;
                else                            ph_d    = ph_q + PW'(1);
            end
            default: begin
                state_d = S_RUN;
                sel_d   = 4'd0;
            end
        endcase
    end

    // Blink runs only outside RUN; cleared whenever RUN is reached.
    always_comb begin
        bcnt_d  = '0;
        blink_d = 1'b0;
        if (state_q != S_RUN) begin
            blink_d = blink_q;
            if (bcnt_q == BW'(BLINK_HALF - 1)) blink_d = ~blink_q;
            else                               bcnt_d  = bcnt_q + BW'(1);
        end
    end

    // Outputs decode straight from state so a reset drops add/clr at once.
    always_comb begin
        adjust = (state_q == S_RUN);
        select = sel_q;
        add    = (state_q == S_PULSE) && !op_clr_q;
        clr    = ((state_q == S_PULSE) && op_clr_q) ||
                 (((state_q == S_ZMS0) || (state_q == S_ZMS1)) && (ph_q < PW'(PULSE_CYC)));
        blink  = blink_q && (state_q != S_RUN);
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            sel_q       <= 4'd0;
            ph_q        <= '0;
            op_clr_q    <= 1'b0;
            mode_pend_q <= 1'b0;
            to_q        <= '0;
            bcnt_q      <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ph_q        <= ph_d;
            op_clr_q    <= op_clr_d;
            mode_pend_q <= mode_pend_d;
            to_q        <= to_d;
            bcnt_q      <= bcnt_d;
            blink_q     <= blink_d;
        end
    end
endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Bench for time_adjust_ctrl: table of next-key steps, scoreboard of expected
// add/clr pulses, and hand-timed sequences for the multi-cycle corners.
module tb_time_adjust_ctrl;
    localparam int DEB = 4, PC = 2, RD = 20, RR = 8, TO = 100, BH = 10;
    localparam int K_MODE = 0, K_NEXT = 1, K_ADD = 2, K_CLR = 3;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b0;
    logic [3:0] keys_n   = 4'hF;
    logic       adjust, add, clr, blink;
    logic [3:0] select;

    time_adjust_ctrl #(
        .DEB_CYC(DEB), .PULSE_CYC(PC), .REP_DELAY(RD), .REP_RATE(RR),
        .TIMEOUT_CYC(TO), .BLINK_HALF(BH)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n),
        .key_mode(keys_n[K_MODE]), .key_next(keys_n[K_NEXT]),
        .key_add(keys_n[K_ADD]), .key_clr(keys_n[K_CLR]),
        .adjust(adjust), .select(select), .add(add), .clr(clr), .blink(blink)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct { logic is_clr; logic [3:0] sel; } exp_t;
    typedef struct { int key; int hold; logic exp_adj; logic [3:0] exp_sel; } vec_t;

    exp_t sb[$];
    int   add_starts[$];
    vec_t vecs[14];
    int   checks = 0, errors = 0, cyc = 0;
    bit   in_p = 0, prev_hi = 0;
    int   width = 0;
    logic [3:0] psel = 4'd0;
    bit   found;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse monitor: invariants every cycle, scoreboard pop at each rising edge.
    task automatic mon();
        exp_t e;
        if (!rst_n) begin
            in_p    = 0;
            prev_hi = 0;
            return;
        end
        check("add_clr_exclusive", int'(add & clr), 0);
        check("no_pulse_in_run", int'(adjust & (add | clr)), 0);
        if ((add || clr) && !prev_hi) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: add=%0d clr=%0d sel=%0d cycle %0d", add, clr, select, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind_is_clr", int'(clr), int'(e.is_clr));
                check("pulse_sel", int'(select), int'(e.sel));
            end
            in_p  = 1;
            width = 1;
            psel  = select;
            if (add) add_starts.push_back(cyc);
        end else if (add || clr) begin
            width++;
            check("sel_stable_in_pulse", int'(select), int'(psel));
        end else if (in_p) begin
            in_p = 0;
            check("pulse_width", width, PC);
        end
        prev_hi = add | clr;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_50);
            #1;
            cyc++;
            mon();
        end
    endtask

    task automatic press(input int k);
        keys_n[k] = 1'b0;
        step(9);
        keys_n[k] = 1'b1;
        step(9);
    endtask

    // Bounded wait for adjust to fall (entry to ZMS0).
    task automatic wait_edit_entry();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            found = (adjust == 1'b0);
        end
        check("edit_entry_seen", int'(found), 1);
    endtask

    initial begin
        for (int i = 0; i < 14; i++)
            vecs[i] = '{K_NEXT, 9, 1'b0, (i + 3 <= 15) ? 4'(i + 3) : 4'd2};

        // 1: reset state, reset mid-run, bounce rejection
        step(3);
        check("rst_adjust", int'(adjust), 1);
        check("rst_select", int'(select), 0);
        check("rst_add", int'(add), 0);
        check("rst_clr", int'(clr), 0);
        check("rst_blink", int'(blink), 0);
        rst_n = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_adjust", int'(adjust), 1);
        check("rst_mid_select", int'(select), 0);
        step(2);
        rst_n = 1'b1;
        step(3);
        for (int i = 0; i < 5; i++) begin
            keys_n[K_MODE] = 1'b0;
            step(1);
            keys_n[K_MODE] = 1'b1;
            step(1);
        end
        step(15);
        check("bounce_adjust", int'(adjust), 1);
        check("bounce_select", int'(select), 0);

        // 2: enter EDIT, zero both ms digits
        sb.push_back('{1'b1, 4'd0});
        sb.push_back('{1'b1, 4'd1});
        keys_n[K_MODE] = 1'b0;
        wait_edit_entry();
        check("zms_c0_clr", int'(clr), 1);
        check("zms_c0_sel", int'(select), 0);
        step(1); check("zms_c1_clr", int'(clr), 1);
        step(1); check("zms_c2_clr", int'(clr), 0);
        step(1); check("zms_c3_clr", int'(clr), 0);
        step(1); check("zms_c4_clr", int'(clr), 1);
        check("zms_c4_sel", int'(select), 1);
        step(1); check("zms_c5_clr", int'(clr), 1);
        step(1); check("zms_c6_clr", int'(clr), 0);
        step(2);
        check("edit_sel", int'(select), 2);
        check("edit_adjust", int'(adjust), 0);
        keys_n[K_MODE] = 1'b1;
        step(10);

        // 3: next-key walk through the table, wrapping 15 -> 2
        foreach (vecs[i]) begin
            press(vecs[i].key);
            check("next_sel", int'(select), int'(vecs[i].exp_sel));
            check("next_adjust", int'(adjust), int'(vecs[i].exp_adj));
        end

        // 4: held add -> press pulse plus two repeats at +20 and +28
        add_starts.delete();
        for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 4'd2});
        keys_n[K_ADD] = 1'b0;
        step(32);
        keys_n[K_ADD] = 1'b1;
        step(20);
        check("repeat_count", add_starts.size(), 3);
        if (add_starts.size() == 3) begin
            check("repeat_delay", add_starts[1] - add_starts[0], RD);
            check("repeat_rate", add_starts[2] - add_starts[1], RR);
        end

        // 5: clr+add together -> clr only; mode during the pulse serviced after GAP
        sb.push_back('{1'b1, 4'd2});
        keys_n[K_CLR] = 1'b0;
        keys_n[K_ADD] = 1'b0;
        step(2);
        keys_n[K_MODE] = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            found = (clr == 1'b1);
        end
        check("clr_pulse_seen", int'(found), 1);
        step(1); check("latched_s1_clr", int'(clr), 1);
        step(1); check("latched_gap_adjust", int'(adjust), 0);
        step(2); check("latched_edit_adjust", int'(adjust), 0);
        step(1);
        check("latched_run_adjust", int'(adjust), 1);
        check("latched_run_select", int'(select), 0);
        keys_n = 4'hF;
        step(12);

        // 6: idle timeout with blink, then reset during an add pulse
        sb.push_back('{1'b1, 4'd0});
        sb.push_back('{1'b1, 4'd1});
        keys_n[K_MODE] = 1'b0;
        wait_edit_entry();
        keys_n[K_MODE] = 1'b1;
        step(8);
        check("to_edit_sel", int'(select), 2);
        step(4);  check("blink_on", int'(blink), 1);
        step(10); check("blink_off", int'(blink), 0);
        step(84); check("to_before_adjust", int'(adjust), 0);
        step(3);
        check("to_adjust", int'(adjust), 1);
        check("to_select", int'(select), 0);
        check("to_blink", int'(blink), 0);

        sb.push_back('{1'b1, 4'd0});
        sb.push_back('{1'b1, 4'd1});
        keys_n[K_MODE] = 1'b0;
        wait_edit_entry();
        keys_n[K_MODE] = 1'b1;
        step(8);
        sb.push_back('{1'b0, 4'd2});
        keys_n[K_ADD] = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1);
            found = (add == 1'b1);
        end
        check("add_pulse_seen", int'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pulse_add", int'(add), 0);
        check("rst_pulse_adjust", int'(adjust), 1);
        keys_n[K_ADD] = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(10);
        check("post_rst_adjust", int'(adjust), 1);
        check("post_rst_add", int'(add), 0);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
